// File: rtl/lsu_ram_master.sv
// rtl/lsu_ram_master.sv - RV32I byte-addressed load/store initiator for a 1024x32 word RAM
// Optional upper-address range check: LSU_RANGE_CHECK_EN
module lsu_ram_master #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ,
    input  logic              WE,
    input  logic [2:0]        FUNCT3,
    input  logic [31:0]       ADDR,
    input  logic [DATA_W-1:0] WDATA,
    output logic              BUSY,
    output logic              DONE,
    output logic [DATA_W-1:0] RDATA,
    output logic              ERR,
    output logic              RAM_ENABLE,
    output logic              RAM_READ,
    output logic              RAM_WRITE,
    output logic [ADDR_W-1:0] RAM_ADDRESS,
    output logic [DATA_W-1:0] RAM_WDATA,
    input  logic [DATA_W-1:0] RAM_RDATA
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state;
    logic        lat_we;
    logic [2:0]  lat_f3;
    logic [1:0]  lat_lane;
    logic [15:0] lat_wdata;

    logic              range_bad;
    logic              illegal;
    logic [4:0]        byte_off;
    logic [4:0]        half_off;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] merge_word;

`ifdef LSU_RANGE_CHECK_EN
    assign range_bad = |ADDR[31:ADDR_W+2];
`else
    // Upper address bits alias into the RAM.
    logic unused_addr_hi;
    assign unused_addr_hi = ^ADDR[31:ADDR_W+2];
    assign range_bad      = 1'b0;
`endif

    always_comb begin
        illegal = (FUNCT3 == 3'b011) || (FUNCT3[2:1] == 2'b11)
               || (WE && FUNCT3[2])
               || ((FUNCT3[1:0] == 2'b01) && ADDR[0])
               || ((FUNCT3[1:0] == 2'b10) && (ADDR[1:0] != 2'b00))
               || range_bad;
    end

    assign byte_off = {lat_lane, 3'b000};
    assign half_off = {lat_lane[1], 4'b0000};
    assign byte_sel = RAM_RDATA[byte_off +: 8];
    assign half_sel = RAM_RDATA[half_off +: 16];

    always_comb begin
        case (lat_f3)
            3'b000:  load_val = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            3'b001:  load_val = {{(DATA_W-16){half_sel[15]}}, half_sel};
            3'b100:  load_val = {{(DATA_W-8){1'b0}}, byte_sel};
            3'b101:  load_val = {{(DATA_W-16){1'b0}}, half_sel};
            default: load_val = RAM_RDATA;
        endcase
    end

    // Sub-word store: replace only the addressed lane of the word just read.
    always_comb begin
        merge_word = RAM_RDATA;
        if (lat_f3[0])
            merge_word[half_off +: 16] = lat_wdata;
        else
            merge_word[byte_off +: 8] = lat_wdata[7:0];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            lat_we      <= 1'b0;
            lat_f3      <= 3'b000;
            lat_lane    <= 2'b00;
            lat_wdata   <= 16'h0000;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            ERR         <= 1'b0;
            RDATA       <= '0;
            RAM_ENABLE  <= 1'b0;
            RAM_READ    <= 1'b0;
            RAM_WRITE   <= 1'b0;
            RAM_ADDRESS <= '0;
            RAM_WDATA   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    DONE <= 1'b0;
                    if (REQ) begin
                        lat_we    <= WE;
                        lat_f3    <= FUNCT3;
                        lat_lane  <= ADDR[1:0];
                        lat_wdata <= WDATA[15:0];
                        BUSY      <= 1'b1;
                        RDATA     <= '0;
                        ERR       <= 1'b0;
                        if (illegal) begin
                            ERR   <= 1'b1;
                            DONE  <= 1'b1;
                            state <= RESP;
                        end else if (!WE || (FUNCT3[1:0] != 2'b10)) begin
                            RAM_ENABLE  <= 1'b1;
                            RAM_READ    <= 1'b1;
                            RAM_ADDRESS <= ADDR[ADDR_W+1:2];
                            state       <= RD;
                        end else begin
                            RAM_ENABLE  <= 1'b1;
                            RAM_WRITE   <= 1'b1;
                            RAM_ADDRESS <= ADDR[ADDR_W+1:2];
                            RAM_WDATA   <= WDATA;
                            state       <= WR;
                        end
                    end
                end
                RD: begin
                    RAM_READ <= 1'b0;
                    if (lat_we) begin
                        RAM_WRITE <= 1'b1;
                        RAM_WDATA <= merge_word;
                        state     <= WR;
                    end else begin
                        RAM_ENABLE <= 1'b0;
                        RDATA      <= load_val;
                        DONE       <= 1'b1;
                        state      <= RESP;
                    end
                end
                WR: begin
                    RAM_ENABLE <= 1'b0;
                    RAM_WRITE  <= 1'b0;
                    RAM_WDATA  <= '0;
                    DONE       <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ram_master.sv
// tb/tb_lsu_ram_master.sv - scoreboard bench for lsu_ram_master with a behavioural 1024x32 RAM
module tb_lsu_ram_master;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        REQ = 1'b0;
    logic        WE = 1'b0;
    logic [2:0]  FUNCT3 = 3'b000;
    logic [31:0] ADDR = 32'h0;
    logic [31:0] WDATA = 32'h0;
    logic        BUSY, DONE, ERR;
    logic [31:0] RDATA;
    logic        RAM_ENABLE, RAM_READ, RAM_WRITE;
    logic [9:0]  RAM_ADDRESS;
    logic [31:0] RAM_WDATA;
    logic [31:0] RAM_RDATA;

    lsu_ram_master #(.ADDR_W(10), .DATA_W(32)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .WE(WE), .FUNCT3(FUNCT3),
        .ADDR(ADDR), .WDATA(WDATA), .BUSY(BUSY), .DONE(DONE), .RDATA(RDATA),
        .ERR(ERR), .RAM_ENABLE(RAM_ENABLE), .RAM_READ(RAM_READ),
        .RAM_WRITE(RAM_WRITE), .RAM_ADDRESS(RAM_ADDRESS),
        .RAM_WDATA(RAM_WDATA), .RAM_RDATA(RAM_RDATA)
    );

    always #5 CLK = ~CLK;

    logic [31:0] mem [1024];
    logic [31:0] sm  [1024];
    assign RAM_RDATA = (RAM_ENABLE && RAM_READ) ? mem[RAM_ADDRESS] : 32'h0;
    always @(posedge CLK) if (RAM_ENABLE && RAM_WRITE) mem[RAM_ADDRESS] <= RAM_WDATA;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nacc;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          nacc = 0;
    int          nwrites = 0;
    logic [9:0]  exp_addr = 10'h0;
    logic [31:0] exp_wr = 32'h0;
    logic [31:0] last_rdata = 32'h0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour: computes the expected response and updates the shadow memory.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output exp_t e, output logic [31:0] wr_word);
        logic        ill;
        logic [31:0] w, b, h;
        int          sh, sh2;
        ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2])
           || (((f3 == 3'd1) || (f3 == 3'd5)) && a[0])
           || ((f3 == 3'd2) && (a[1:0] != 2'b00));
`ifdef LSU_RANGE_CHECK_EN
        ill = ill || (a[31:12] != 20'h0);
`endif
        w   = sm[a[11:2]];
        sh  = int'(a[1:0]) * 8;
        sh2 = a[1] ? 16 : 0;
        b   = (w >> sh) & 32'hFF;
        h   = (w >> sh2) & 32'hFFFF;
        e.rdata = 32'h0;
        e.err   = ill;
        e.acc   = 0;
        wr_word = 32'h0;
        if (ill) begin
            e.lat = 1; e.nacc = 0;
        end else if (!we) begin
            e.lat = 2; e.nacc = 1;
            case (f3)
                3'd0:    e.rdata = b[7] ? (b | 32'hFFFFFF00) : b;
                3'd1:    e.rdata = h[15] ? (h | 32'hFFFF0000) : h;
                3'd4:    e.rdata = b;
                3'd5:    e.rdata = h;
                default: e.rdata = w;
            endcase
        end else if (f3 == 3'd2) begin
            e.lat = 2; e.nacc = 1; wr_word = wd;
        end else begin
            e.lat = 3; e.nacc = 2;
            if (f3 == 3'd0) wr_word = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
            else            wr_word = (w & ~(32'hFFFF << sh2)) | ((wd & 32'hFFFF) << sh2);
        end
        if (!ill && we) sm[a[11:2]] = wr_word;
    endfunction

    always @(negedge CLK) begin
        if (RESET) begin
            nacc = 0;
        end else begin
            check("strobe_rules",
                  {31'h0, (RAM_READ & RAM_WRITE) | (RAM_ENABLE != (RAM_READ | RAM_WRITE))
                          | (!RAM_WRITE && RAM_WDATA != 32'h0) | (DONE & !BUSY)}, 32'h0);
            if (RAM_ENABLE) begin
                nacc++;
                check("ram_address", {22'h0, RAM_ADDRESS}, {22'h0, exp_addr});
            end
            if (RAM_WRITE) begin
                nwrites++;
                check("ram_wdata", RAM_WDATA, exp_wr);
            end
            if (DONE) begin
                if (sb.size() == 0) begin
                    check("spurious_done", {31'h0, DONE}, 32'h0);
                end else begin
                    mon_e = sb.pop_front();
                    check("rdata", RDATA, mon_e.rdata);
                    check("err", {31'h0, ERR}, {31'h0, mon_e.err});
                    check("latency", cyc - mon_e.acc + 1, mon_e.lat);
                    check("ram_accesses", nacc, mon_e.nacc);
                    last_rdata = RDATA;
                end
                nacc = 0;
            end
        end
    end

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        logic [31:0] ww;
        int          n;
        n = 0;
        @(negedge CLK);
        while (BUSY && n < 20) begin @(negedge CLK); n++; end
        check("idle_before_req", {31'h0, BUSY}, 32'h0);
        model(we, f3, a, wd, e, ww);
        exp_addr = a[11:2];
        exp_wr   = ww;
        REQ = 1'b1; WE = we; FUNCT3 = f3; ADDR = a; WDATA = wd;
        @(posedge CLK); #1;
        e.acc = cyc;
        sb.push_back(e);
        REQ = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 20) begin @(posedge CLK); n++; end
        check("done_seen", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        exp_t        e;
        logic [31:0] ww, saved;
        int          mism;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = (i * 32'h01010101) ^ 32'h5A00C300;
            sm[i]  = mem[i];
        end

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_flags", {26'h0, BUSY, DONE, ERR, RAM_ENABLE, RAM_READ, RAM_WRITE}, 32'h0);
        check("reset_rdata", RDATA, 32'h0);
        check("reset_ram_address", {22'h0, RAM_ADDRESS}, 32'h0);
        check("reset_ram_wdata", RAM_WDATA, 32'h0);
        RESET = 1'b0;

        do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        do_req(1'b0, 3'd2, 32'h10, 32'h0);
        check("lw_0x10", last_rdata, 32'hDEADBEEF);
        do_req(1'b1, 3'd0, 32'h13, 32'h000000A5);
        check("word4_after_sb", mem[4], 32'hA5ADBEEF);
        do_req(1'b0, 3'd0, 32'h13, 32'h0);
        check("lb_0x13", last_rdata, 32'hFFFFFFA5);
        do_req(1'b0, 3'd4, 32'h13, 32'h0);
        check("lbu_0x13", last_rdata, 32'h000000A5);
        do_req(1'b1, 3'd1, 32'h12, 32'h00001234);
        check("word4_after_sh", mem[4], 32'h1234BEEF);
        do_req(1'b0, 3'd1, 32'h12, 32'h0);
        check("lh_0x12", last_rdata, 32'h00001234);
        do_req(1'b0, 3'd1, 32'h10, 32'h0);
        check("lh_0x10", last_rdata, 32'hFFFFBEEF);
        do_req(1'b0, 3'd5, 32'h10, 32'h0);
        check("lhu_0x10", last_rdata, 32'h0000BEEF);

        do_req(1'b0, 3'd2, 32'h11, 32'h0);
        do_req(1'b1, 3'd1, 32'h13, 32'hFFFF);
        do_req(1'b0, 3'd3, 32'h10, 32'h0);
        do_req(1'b1, 3'd4, 32'h10, 32'h0);
        do_req(1'b0, 3'd2, 32'h1010, 32'h0);

        // REQ held for ten edges: accepts expected at edges 0, 3, 6, 9.
        @(negedge CLK);
        check("held_idle_start", {31'h0, BUSY}, 32'h0);
        exp_addr = 10'd4;
        REQ = 1'b1; WE = 1'b0; FUNCT3 = 3'd2; ADDR = 32'h10; WDATA = 32'h0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            if (i % 3 == 0) begin
                model(1'b0, 3'd2, 32'h10, 32'h0, e, ww);
                e.acc = cyc;
                sb.push_back(e);
            end
            @(negedge CLK);
            check("held_busy", {31'h0, BUSY}, {31'h0, (i % 3) != 2});
            if (i == 9) REQ = 1'b0;
        end
        begin
            int n;
            n = 0;
            while (sb.size() != 0 && n < 20) begin @(posedge CLK); n++; end
            check("held_done_seen", sb.size(), 0);
            sb.delete();
        end

        // Reset during the read phase of an SB must suppress the write.
        @(negedge CLK);
        while (BUSY) @(negedge CLK);
        saved    = mem[5];
        exp_addr = 10'd5;
        REQ = 1'b1; WE = 1'b1; FUNCT3 = 3'd0; ADDR = 32'h15; WDATA = 32'h5A;
        @(posedge CLK); #1;
        REQ = 1'b0;
        check("rst_rd_phase", {31'h0, RAM_READ}, 32'h1);
        RESET = 1'b1;
        mism = nwrites;
        @(posedge CLK); #1;
        RESET = 1'b0;
        check("rst_flags", {28'h0, BUSY, DONE, RAM_ENABLE, RAM_WRITE}, 32'h0);
        repeat (3) @(negedge CLK);
        check("rst_no_write", nwrites, mism);
        check("rst_word_kept", mem[5], saved);
        do_req(1'b0, 3'd2, 32'h14, 32'h0);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            a = $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) a = a | 32'h0000_3000;
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
        end

        mism = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== sm[i]) mism++;
        check("final_memory", mism, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
